// File: rtl/mpc_sequencer_pkg.sv
// Shared microsequencer constants: COND encodings, ALU flag bit positions, bus widths.
// Also used by the MIR and control-store blocks so field encodings stay in one place.
package mpc_sequencer_pkg;

    localparam int JUMP_ADDR_BUS_WIDTH = 11;
    localparam int COND_BUS_WIDTH      = 3;
    localparam int STACK_DEPTH         = 4;

    // Bit positions within the {N,Z,C,V} flag bus
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [COND_BUS_WIDTH-1:0] {
        COND_NEXT = 3'd0,
        COND_JN   = 3'd1,
        COND_JZ   = 3'd2,
        COND_JC   = 3'd3,
        COND_JV   = 3'd4,
        COND_JMP  = 3'd5,
        COND_CALL = 3'd6,
        COND_RET  = 3'd7
    } cond_e;

endpackage

// File: rtl/mpc_return_stack.sv
// Micro-subroutine return-address LIFO with registered entries and synchronous reset.
// Latency: push/pop take effect at the next rising edge; top_dat is a combinational read.
// Backpressure: none; push while full and pop while empty are ignored, callers check full/empty.
module mpc_return_stack #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_dat,
    output logic [WIDTH-1:0] top_dat,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full (DEPTH) from empty (0)
    logic [PW:0]      sp;
    logic [WIDTH-1:0] entries [DEPTH];

    assign full    = (sp == (PW+1)'(DEPTH));
    assign empty   = (sp == '0);
    assign top_dat = entries[sp[PW-1:0] - PW'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push && !full) begin
            entries[sp[PW-1:0]] <= push_dat;
            sp                  <= sp + (PW+1)'(1);
        end else if (pop && !empty) begin
            sp <= sp - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/mpc_sequencer.sv
// Microprogram sequencer: selects the next control-store address from COND, ALU flags and a return stack.
// Latency: COND/flags in cycle n give a new MPC after rising edge n+1; STALL is combinational.
// Backpressure: RD/WR without MEM_READY stalls, freezing MPC, stack and sticky flags.
module mpc_sequencer
    import mpc_sequencer_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                           MPCSEQ_CLOCK_50,
    input  logic                           MPCSEQ_RESET_IN,
    input  logic [COND_BUS_WIDTH-1:0]      MPCSEQ_COND_IN,
    input  logic [JUMP_ADDR_BUS_WIDTH-1:0] MPCSEQ_JUMP_ADDR_IN,
    input  logic                           MPCSEQ_RD_IN,
    input  logic                           MPCSEQ_WR_IN,
    input  logic                           MPCSEQ_MEM_READY_IN,
    input  logic [3:0]                     MPCSEQ_FLAGS_IN,
    output logic [JUMP_ADDR_BUS_WIDTH-1:0] MPCSEQ_MPC_OUT,
    output logic                           MPCSEQ_STALL_OUT,
    output logic                           MPCSEQ_OVERFLOW_OUT,
    output logic                           MPCSEQ_UNDERFLOW_OUT
);

    logic [JUMP_ADDR_BUS_WIDTH-1:0] mpc;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] mpc_inc;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] mpc_nxt;
    logic [JUMP_ADDR_BUS_WIDTH-1:0] stk_top_dat;
    logic                           stk_full;
    logic                           stk_empty;
    logic                           stk_push;
    logic                           stk_pop;
    logic                           set_ovf;
    logic                           set_unf;
    logic                           ovf;
    logic                           unf;
    logic                           stall;

    assign stall   = (MPCSEQ_RD_IN | MPCSEQ_WR_IN) & ~MPCSEQ_MEM_READY_IN;
    assign mpc_inc = mpc + JUMP_ADDR_BUS_WIDTH'(1);

    // Decisions are computed unconditionally; stall gates the stack strobes and the register update
    always_comb begin
        mpc_nxt  = mpc_inc;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        case (cond_e'(MPCSEQ_COND_IN))
            COND_NEXT: mpc_nxt = mpc_inc;
            COND_JN:   if (MPCSEQ_FLAGS_IN[FLAG_N]) mpc_nxt = MPCSEQ_JUMP_ADDR_IN;
            COND_JZ:   if (MPCSEQ_FLAGS_IN[FLAG_Z]) mpc_nxt = MPCSEQ_JUMP_ADDR_IN;
            COND_JC:   if (MPCSEQ_FLAGS_IN[FLAG_C]) mpc_nxt = MPCSEQ_JUMP_ADDR_IN;
            COND_JV:   if (MPCSEQ_FLAGS_IN[FLAG_V]) mpc_nxt = MPCSEQ_JUMP_ADDR_IN;
            COND_JMP:  mpc_nxt = MPCSEQ_JUMP_ADDR_IN;
            COND_CALL: begin
                mpc_nxt = MPCSEQ_JUMP_ADDR_IN;
                if (stk_full) set_ovf  = 1'b1;
                else          stk_push = ~stall;
            end
            COND_RET: begin
                if (stk_empty) begin
                    mpc_nxt = '0;
                    set_unf = 1'b1;
                end else begin
                    mpc_nxt = stk_top_dat;
                    stk_pop = ~stall;
                end
            end
            default: mpc_nxt = mpc_inc;
        endcase
    end

    always_ff @(posedge MPCSEQ_CLOCK_50) begin
        if (MPCSEQ_RESET_IN) begin
            mpc <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (!stall) begin
            mpc <= mpc_nxt;
            ovf <= ovf | set_ovf;
            unf <= unf | set_unf;
        end
    end

    mpc_return_stack #(
        .WIDTH (JUMP_ADDR_BUS_WIDTH),
        .DEPTH (DEPTH)
    ) u_return_stack (
        .clk      (MPCSEQ_CLOCK_50),
        .rst      (MPCSEQ_RESET_IN),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_dat (mpc_inc),
        .top_dat  (stk_top_dat),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    assign MPCSEQ_MPC_OUT       = mpc;
    assign MPCSEQ_STALL_OUT     = stall;
    assign MPCSEQ_OVERFLOW_OUT  = ovf;
    assign MPCSEQ_UNDERFLOW_OUT = unf;

endmodule

// File: tb/tb_mpc_sequencer.sv
// Scoreboard bench for mpc_sequencer: a behavioural model pushes expected MPC/sticky state per cycle,
// popped and compared one edge later; directed scenarios plus a random tail.
module tb_mpc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cond;
    logic [10:0] jaddr;
    logic        rd;
    logic        wr;
    logic        rdy;
    logic [3:0]  flags;
    logic [10:0] mpc;
    logic        stall;
    logic        ovf;
    logic        unf;

    typedef struct packed {
        logic [10:0] mpc;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb [$];
    logic [10:0] m_stk [$];
    logic [10:0] m_mpc;
    logic        m_ovf;
    logic        m_unf;
    int          n_vec;
    int          n_err;

    always #5 clk = ~clk;

    mpc_sequencer dut (
        .MPCSEQ_CLOCK_50      (clk),
        .MPCSEQ_RESET_IN      (rst),
        .MPCSEQ_COND_IN       (cond),
        .MPCSEQ_JUMP_ADDR_IN  (jaddr),
        .MPCSEQ_RD_IN         (rd),
        .MPCSEQ_WR_IN         (wr),
        .MPCSEQ_MEM_READY_IN  (rdy),
        .MPCSEQ_FLAGS_IN      (flags),
        .MPCSEQ_MPC_OUT       (mpc),
        .MPCSEQ_STALL_OUT     (stall),
        .MPCSEQ_OVERFLOW_OUT  (ovf),
        .MPCSEQ_UNDERFLOW_OUT (unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One microcycle: drive at negedge, check STALL, model the edge, compare after the edge
    task automatic cyc(input logic r, input logic [2:0] c, input logic [10:0] ja,
                       input logic rd_i, input logic wr_i, input logic rdy_i, input logic [3:0] fl);
        logic e_stall;
        exp_t e;
        rst = r; cond = c; jaddr = ja; rd = rd_i; wr = wr_i; rdy = rdy_i; flags = fl;
        #1;
        e_stall = (rd_i | wr_i) & ~rdy_i;
        chk("stall", 32'(stall), 32'(e_stall));
        if (r) begin
            m_mpc = '0; m_ovf = 1'b0; m_unf = 1'b0;
            m_stk.delete();
        end else if (!e_stall) begin
            case (c)
                3'd0: m_mpc = m_mpc + 11'd1;
                3'd1: m_mpc = fl[3] ? ja : m_mpc + 11'd1;
                3'd2: m_mpc = fl[2] ? ja : m_mpc + 11'd1;
                3'd3: m_mpc = fl[1] ? ja : m_mpc + 11'd1;
                3'd4: m_mpc = fl[0] ? ja : m_mpc + 11'd1;
                3'd5: m_mpc = ja;
                3'd6: begin
                    if (m_stk.size() >= 4) m_ovf = 1'b1;
                    else m_stk.push_back(m_mpc + 11'd1);
                    m_mpc = ja;
                end
                default: begin
                    if (m_stk.size() == 0) begin
                        m_mpc = '0;
                        m_unf = 1'b1;
                    end else begin
                        m_mpc = m_stk.pop_back();
                    end
                end
            endcase
        end
        sb.push_back('{mpc: m_mpc, ovf: m_ovf, unf: m_unf});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("mpc", 32'(mpc), 32'(e.mpc));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("unf", 32'(unf), 32'(e.unf));
        @(negedge clk);
    endtask

    task automatic op(input logic [2:0] c, input logic [10:0] ja, input logic [3:0] fl);
        cyc(1'b0, c, ja, 1'b0, 1'b0, 1'b0, fl);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_mpc = '0; m_ovf = 1'b0; m_unf = 1'b0;
        rst = 1'b1; cond = '0; jaddr = '0; rd = 1'b0; wr = 1'b0; rdy = 1'b0; flags = '0;
        @(negedge clk);
        cyc(1'b1, 3'd0, 11'h000, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("reset_mpc", 32'(mpc), 32'h0);

        // Reset mid-run beats a CALL and a stall on the same edge
        op(3'd5, 11'h155, 4'h0);
        chk("t1_at_155", 32'(mpc), 32'h155);
        op(3'd6, 11'h2AA, 4'h0);
        cyc(1'b1, 3'd6, 11'h3FF, 1'b1, 1'b0, 1'b0, 4'hF);
        chk("t1_reset_mpc", 32'(mpc), 32'h0);
        op(3'd6, 11'h050, 4'h0);
        op(3'd7, 11'h000, 4'h0);
        chk("t1_ret_entry0", 32'(mpc), 32'h001);
        op(3'd7, 11'h000, 4'h0);
        chk("t1_unf_after_reset", 32'(unf), 32'h1);
        cyc(1'b1, 3'd0, 11'h000, 1'b0, 1'b0, 1'b0, 4'h0);

        // 11-bit wrap of MPC+1
        op(3'd5, 11'h7FF, 4'h0);
        op(3'd0, 11'h123, 4'hF);
        chk("t2_wrap", 32'(mpc), 32'h000);

        // Conditional jumps, taken and not taken
        op(3'd5, 11'h010, 4'h0);
        op(3'd2, 11'h200, 4'b0100);
        chk("t3_jz_taken", 32'(mpc), 32'h200);
        op(3'd5, 11'h010, 4'h0);
        op(3'd2, 11'h200, 4'b1011);
        chk("t3_jz_not", 32'(mpc), 32'h011);
        op(3'd1, 11'h0A0, 4'b1000);
        op(3'd1, 11'h0B0, 4'b0111);
        op(3'd3, 11'h0C0, 4'b0010);
        op(3'd3, 11'h0D0, 4'b1101);
        op(3'd4, 11'h0E0, 4'b0001);
        op(3'd4, 11'h0F0, 4'b1110);

        // Memory stall: three cycles held, flags and COND ignored
        op(3'd5, 11'h020, 4'h0);
        cyc(1'b0, 3'd5, 11'h300, 1'b1, 1'b0, 1'b0, 4'hF);
        cyc(1'b0, 3'd2, 11'h300, 1'b1, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 3'd7, 11'h300, 1'b1, 1'b0, 1'b0, 4'hF);
        chk("t4_hold", 32'(mpc), 32'h020);
        cyc(1'b0, 3'd5, 11'h040, 1'b1, 1'b0, 1'b1, 4'h0);
        chk("t4_release", 32'(mpc), 32'h040);
        cyc(1'b0, 3'd6, 11'h444, 1'b0, 1'b1, 1'b0, 4'h0);
        cyc(1'b0, 3'd0, 11'h000, 1'b0, 1'b1, 1'b1, 4'h0);

        // Nested calls and returns
        cyc(1'b1, 3'd0, 11'h000, 1'b0, 1'b0, 1'b0, 4'h0);
        op(3'd5, 11'h100, 4'h0);
        op(3'd6, 11'h300, 4'h0);
        op(3'd6, 11'h500, 4'h0);
        op(3'd6, 11'h600, 4'h0);
        op(3'd7, 11'h000, 4'h0);
        chk("t5_ret1", 32'(mpc), 32'h501);
        op(3'd7, 11'h000, 4'h0);
        chk("t5_ret2", 32'(mpc), 32'h301);
        op(3'd7, 11'h000, 4'h0);
        chk("t5_ret3", 32'(mpc), 32'h101);

        // Overflow on the fifth call, underflow on the fifth return
        cyc(1'b1, 3'd0, 11'h000, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 1; i <= 5; i++) op(3'd6, 11'(i * 16), 4'h0);
        chk("t6_ovf", 32'(ovf), 32'h1);
        chk("t6_5th_jump", 32'(mpc), 32'h050);
        for (int i = 0; i < 5; i++) op(3'd7, 11'h000, 4'h0);
        chk("t6_unf_mpc", 32'(mpc), 32'h000);
        chk("t6_unf", 32'(unf), 32'h1);
        op(3'd0, 11'h000, 4'h0);
        op(3'd6, 11'h222, 4'h0);
        op(3'd7, 11'h000, 4'h0);
        chk("t6_ovf_sticky", 32'(ovf), 32'h1);
        cyc(1'b1, 3'd0, 11'h000, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("t6_clear", 32'({ovf, unf}), 32'h0);
        cyc(1'b0, 3'd7, 11'h000, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("t6_stalled_ret", 32'(unf), 32'h0);

        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)), 11'($urandom),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 2) != 0), 4'($urandom));
        end

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
